ddr3_app_arbiter: RTL
=====================

// Module: ddr3_app_arbiter
// PURPOSE
//  Two-port arbiter and sequencer in front of the DDR3 memory interface application port.
//  Two requesters (port 0, port 1) each issue single-beat 128-bit reads/writes.
//  Requests are granted round-robin and driven onto cmd/addr/wr_data.
//  Read data is returned to the granted port, with a timeout guard on reads.
// PARAMETERS
//  ADDR_W  28   app address width
//  DATA_W  128  app data width
//  MASK_W  16   byte-mask width (DATA_W/8); mask bit = 1 means byte NOT written
//  RD_TMO  255  max clk cycles from read cmd accept to rd_data_valid before error
// PORTS
//  clk                  in   1       app clock (DDR3 clk_out domain); one clock only
//  rst_n                in   1       async active-low reset
//  init_calib_complete  in   1       DDR3 calibration done; no grants while 0
//  pN_req               in   1       port N (N=0,1) request, held until pN_ack/pN_err
//  pN_we                in   1       1=write, 0=read; stable while pN_req
//  pN_addr              in   ADDR_W  beat address; stable while pN_req
//  pN_wdata             in   DATA_W  write data
//  pN_wmask             in   MASK_W  write byte mask
//  pN_ack               out  1       1-cycle completion pulse
//  pN_err               out  1       1-cycle read-timeout pulse (instead of ack)
//  pN_rdata             out  DATA_W  read data, valid with pN_ack, held until next read to port N
//  cmd                  out  3       3'd0 write, 3'd1 read
//  cmd_en               out  1       command strobe
//  addr                 out  ADDR_W  command address
//  cmd_ready            in   1       interface accepts command when 1
//  wr_data              out  DATA_W  write beat
//  wr_data_en           out  1       write beat strobe
//  wr_data_end          out  1       last beat (always = wr_data_en, single beat)
//  wr_data_mask         out  MASK_W  write byte mask
//  wr_data_rdy          in   1       interface accepts write beat when 1
//  rd_data              in   DATA_W  read beat
//  rd_data_valid        in   1       read beat valid
//  app_burst_number     out  6       constant 6'd0 (one beat)
// BEHAVIOUR
//  Reset: all outputs 0 except app_burst_number=0; FSM=IDLE; last_gnt=1 (port 0 wins first tie); tmo_cnt=0.
//  FSM states and transitions:
//  - IDLE: if calib && (p0_req|p1_req), latch sel and register addr/we/wdata/wmask -> CMD.
//    Sel: the sole requester, or on tie ~last_gnt.
//  - CMD: cmd_en=1, cmd={2'b0,~we}, addr. On cmd_ready: last_gnt<=sel; we ? WDATA : RWAIT.
//  - WDATA: wr_data_en=wr_data_end=1 with registered data/mask. On wr_data_rdy: psel_ack=1 next cycle -> IDLE.
//  - RWAIT: tmo_cnt++ per cycle. On rd_data_valid: psel_rdata<=rd_data, psel_ack=1 next cycle -> IDLE.
//    If tmo_cnt==RD_TMO without valid: psel_err=1 next cycle -> IDLE.
//  Latency: best case write = 3 cycles req->ack (IDLE, CMD, WDATA, ack); read = 2 + memory latency.
//  cmd_en/wr_data_en held asserted, with stable values, until the respective ready is sampled 1.
//  rd_data_valid outside RWAIT: ignored. rd_data_valid and timeout in the same cycle: data wins (ack, no err).
//  Requester dropping req mid-transaction: transaction completes; ack is still pulsed.
//  One outstanding transaction total; the other port waits; no starvation (strict alternation under load).
//  calib dropping mid-transaction: the current transaction finishes; no new grant until calib=1.
//  Async reset mid-transaction: immediate return to reset state; in-flight cmd abandoned, no ack.
//  tmo_cnt width: clog2(RD_TMO+1); cleared on entering RWAIT.
// TESTING
//  - calib=0, p0 write req -> no cmd_en until calib=1; then cmd=0, addr=p0_addr, one wr_data_en beat, p0_ack one pulse.
//  - p0 write 0x00000040 data A5..A5 mask 0, then p1 read 0x40 with memory model -> p1_rdata=A5..A5, p1_ack.
//  - p0_req and p1_req held high for 6 transactions -> grant order 0,1,0,1,0,1.
//  - cmd_ready low 5 cycles in CMD -> cmd_en/addr stable for 5 cycles, single command accepted.
//  - read with rd_data_valid never asserted, RD_TMO=8 -> pN_err pulses once; no ack; FSM back to IDLE.
//  - rst_n asserted in WDATA -> all outputs 0 same cycle; after release, p0 wins a simultaneous request.

Source files
------------

// File: rtl/ddr3_app_arbiter.sv
// Two-port round-robin arbiter/sequencer for the DDR3 application port.
// One single-beat transaction in flight at a time; reads are guarded by a timeout.
module ddr3_app_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16,
  parameter int RD_TMO = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [MASK_W-1:0] p0_wmask,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [MASK_W-1:0] p1_wmask,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [2:0]        cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic              cmd_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_data_en,
  output logic              wr_data_end,
  output logic [MASK_W-1:0] wr_data_mask,
  input  logic              wr_data_rdy,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic [5:0]        app_burst_number
);

  localparam int TMO_W = $clog2(RD_TMO + 1);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RWAIT} state_t;

  state_t           state;
  logic             sel;
  logic             last_gnt;
  logic             we_r;
  logic [TMO_W-1:0] tmo_cnt;

  // On a tie the port that did not win last time gets the grant.
  logic              gnt;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic [MASK_W-1:0] gnt_wmask;

  assign gnt       = (p0_req && p1_req) ? ~last_gnt : p1_req;
  assign gnt_we    = gnt ? p1_we    : p0_we;
  assign gnt_addr  = gnt ? p1_addr  : p0_addr;
  assign gnt_wdata = gnt ? p1_wdata : p0_wdata;
  assign gnt_wmask = gnt ? p1_wmask : p0_wmask;

  assign wr_data_end      = wr_data_en;
  assign app_burst_number = 6'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel          <= 1'b0;
      last_gnt     <= 1'b1;
      we_r         <= 1'b0;
      tmo_cnt      <= '0;
      cmd          <= 3'd0;
      cmd_en       <= 1'b0;
      addr         <= '0;
      wr_data      <= '0;
      wr_data_en   <= 1'b0;
      wr_data_mask <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_err       <= 1'b0;
      p1_err       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (init_calib_complete && (p0_req || p1_req)) begin
            sel          <= gnt;
            we_r         <= gnt_we;
            addr         <= gnt_addr;
            wr_data      <= gnt_wdata;
            wr_data_mask <= gnt_wmask;
            cmd          <= {2'b00, ~gnt_we};
            cmd_en       <= 1'b1;
            state        <= CMD;
          end
        end
        CMD: begin
          if (cmd_ready) begin
            cmd_en   <= 1'b0;
            last_gnt <= sel;
            if (we_r) begin
              wr_data_en <= 1'b1;
              state      <= WDATA;
            end else begin
              tmo_cnt <= '0;
              state   <= RWAIT;
            end
          end
        end
        WDATA: begin
          if (wr_data_rdy) begin
            wr_data_en <= 1'b0;
            p0_ack     <= ~sel;
            p1_ack     <= sel;
            state      <= IDLE;
          end
        end
        RWAIT: begin
          // Data arriving on the timeout cycle still counts as a good read.
          if (rd_data_valid) begin
            if (sel) p1_rdata <= rd_data;
            else     p0_rdata <= rd_data;
            p0_ack <= ~sel;
            p1_ack <= sel;
            state  <= IDLE;
          end else if (tmo_cnt == TMO_W'(RD_TMO)) begin
            p0_err <= ~sel;
            p1_err <= sel;
            state  <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
